credit_sequencer: RTL
=====================

# credit_sequencer

Turns player start requests into arcade coin and start pulses for the pacman core, replacing the plain OR of the start buttons onto the coin input. A start-1 request produces one coin pulse and then a start-1 pulse; a start-2 request produces two coin pulses and then a start-2 pulse. All pulse widths are measured in video frames, counted on VBLANK rising edges, so the game's once-per-frame input sampling always sees every edge. Sits between the merged keyboard/joystick controls and `in0_reg`/`in1_reg` in the emu top level.

## Interface
Parameters:
- COIN_FRAMES, 4: coin pulse width in frames (1..255).
- GAP_FRAMES, 8: low time after each coin pulse in frames (1..255).
- START_FRAMES, 4: start pulse width in frames (1..255).

Ports:
- CLK  in  1  system clock (clk_sys).
- RESET_N  in  1  asynchronous, active-low reset.
- VBLANK  in  1  core vertical blank, synchronous to CLK.
- START1_REQ  in  1  level, active high; merged start-1 request.
- START2_REQ  in  1  level, active high; merged start-2 request.
- DN_ACTIVE  in  1  ROM download in progress (ioctl_download).
- COIN  out  1  active-high coin pulse; the top level inverts it into in0_reg.
- START1  out  1  active-high start-1 pulse.
- START2  out  1  active-high start-2 pulse.
- BUSY  out  1  high in any state except IDLE.

## Operation
- Frame tick: `tick` is a one-CLK pulse on each rising edge of VBLANK, detected with a registered copy of VBLANK.
- Request accept: only in IDLE, on a rising edge of START1_REQ or START2_REQ.
  - Edges are detected every CLK, not only on frame ticks.
  - A level still held from before reset, or from before the block entered IDLE, is not an edge.
- Coin count: accepting a request loads `coins_left` (2 bits) with 1 for player 1 or 2 for player 2, and latches the player in `plr`.
- State machine, with 8-bit `fcnt` counting frame ticks:
  - IDLE: outputs low. On accept, go to COIN_ON with fcnt=0.
  - COIN_ON: COIN=1. On the tick where fcnt reaches COIN_FRAMES-1, decrement coins_left, set fcnt=0 and go to COIN_GAP.
  - COIN_GAP: outputs low. On the tick where fcnt reaches GAP_FRAMES-1:
    - coins_left≠0: go to COIN_ON.
    - coins_left=0: go to START_ON.
  - START_ON: START1 or START2 (chosen by plr) =1. On the tick where fcnt reaches START_FRAMES-1, go to RELEASE.
  - RELEASE: outputs low. When both REQ inputs are low, go to IDLE.
- fcnt increments only on tick and clears on every state change.
- Simultaneous rising edges on both REQ inputs in the same cycle: player 2 wins.
- REQ edges outside IDLE are ignored; there is no queueing.
- DN_ACTIVE high, in any state: next CLK goes to IDLE, clears fcnt and coins_left, and drives all outputs low. Requests are ignored while DN_ACTIVE is high.
- After DN_ACTIVE falls, a request still held needs a fresh rising edge.

## Timing
- Reset values: COIN=0, START1=0, START2=0, BUSY=0, state=IDLE, fcnt=0, coins_left=0, REQ edge registers=1 (this suppresses false edges after reset).
- All outputs are registered and decoded from state.
- Request edge at cycle n: state=COIN_ON and COIN=1 from cycle n+1. BUSY rises in the same cycle.
- Pulse widths: COIN high for exactly COIN_FRAMES frame ticks; the first partial frame before the first tick is added to that.
- Player 1 total sequence: COIN_FRAMES + GAP_FRAMES + START_FRAMES ticks, plus the initial partial frame.
- Player 2 total sequence: adds COIN_FRAMES + GAP_FRAMES ticks to the player 1 total.
- Exit condition: the last tick in a state triggers the transition in the same cycle that fcnt would have wrapped. fcnt never exceeds the parameter value minus 1.
- RESET_N assertion mid-sequence clears everything immediately (asynchronous reset). There is no pulse truncation glitch beyond the reset edge itself.

## Configuration
- CREDIT_SEQ_DEBOUNCE_EN defined:
  - Each REQ input passes through a filter that changes its output only after the raw input has been stable for 2 consecutive frame ticks.
  - Edge detection and the RELEASE check use the filtered value.
  - Acceptance latency becomes up to 3 frames.
  - Filter state resets to 1, same as the edge registers.
- CREDIT_SEQ_DEBOUNCE_EN undefined: raw REQ inputs are used directly, and no filter logic is instantiated.

## Test plan
- Player 1: reset, VBLANK period 100 CLK, defaults. Pulse START1_REQ for 50 CLK → COIN high for 4 frame ticks (plus partial), then 8 ticks low, then START1 high for 4 ticks. START2 stays 0. BUSY falls once the REQ input is low in RELEASE.
- Player 2: pulse START2_REQ → exactly 2 COIN pulses separated by 8 low ticks, then START2 high for 4 ticks. START1 stays 0.
- Simultaneous requests: raise both REQ inputs in the same cycle → 2 coin pulses, then START2. A START1_REQ edge during COIN_GAP has no effect.
- Held request: hold START1_REQ high through the whole sequence → state waits in RELEASE with BUSY=1. Drop it → IDLE next cycle. Raise it again → a new sequence starts.
- Download abort: assert DN_ACTIVE during the second COIN_ON of a player-2 sequence → all outputs 0 and BUSY=0 next cycle. A REQ rising edge while DN_ACTIVE=1 is ignored.
- Reset: with START2_REQ held high through a RESET_N release → no sequence starts. With CREDIT_SEQ_DEBOUNCE_EN, a 1-frame REQ glitch produces no COIN.

Source files
------------

// File: rtl/credit_sequencer.sv
// rtl/credit_sequencer.sv - frame-timed coin/start pulse sequencer for player start requests.
// Optional REQ debounce filter enabled by defining CREDIT_SEQ_DEBOUNCE_EN.
module credit_sequencer #(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 8,
    parameter int START_FRAMES = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic VBLANK,
    input  logic START1_REQ,
    input  logic START2_REQ,
    input  logic DN_ACTIVE,
    output logic COIN,
    output logic START1,
    output logic START2,
    output logic BUSY
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COIN_ON  = 3'd1,
        COIN_GAP = 3'd2,
        START_ON = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam logic [7:0] COIN_LAST  = 8'(COIN_FRAMES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
    localparam logic [7:0] START_LAST = 8'(START_FRAMES - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] fcnt;
    logic [7:0] fcnt_n;
    logic [1:0] coins_left;
    logic [1:0] coins_n;
    logic       plr;
    logic       plr_n;
    logic       coin_d;
    logic       start1_d;
    logic       start2_d;
    logic       busy_d;

    logic       vblank_q;
    logic       tick;
    logic       req1;
    logic       req2;
    logic       req1_q;
    logic       req2_q;
    logic       edge1;
    logic       edge2;
    logic       accept;
    logic       counting;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= VBLANK;
        end
    end

    assign tick = VBLANK & ~vblank_q;

`ifdef CREDIT_SEQ_DEBOUNCE_EN
    // Output follows the raw input only once it has read the same on two consecutive ticks.
    logic samp1;
    logic samp2;
    logic filt1;
    logic filt2;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            samp1 <= 1'b1;
            samp2 <= 1'b1;
            filt1 <= 1'b1;
            filt2 <= 1'b1;
        end else if (tick) begin
            samp1 <= START1_REQ;
            samp2 <= START2_REQ;
            if (START1_REQ == samp1) begin
                filt1 <= START1_REQ;
            end
            if (START2_REQ == samp2) begin
                filt2 <= START2_REQ;
            end
        end
    end

    assign req1 = filt1;
    assign req2 = filt2;
`else
    assign req1 = START1_REQ;
    assign req2 = START2_REQ;
`endif

    // Edge registers reset high so a request held across reset is not seen as new.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req1_q <= 1'b1;
            req2_q <= 1'b1;
        end else begin
            req1_q <= req1;
            req2_q <= req2;
        end
    end

    assign edge1  = req1 & ~req1_q;
    assign edge2  = req2 & ~req2_q;
    assign accept = (state == IDLE) & ~DN_ACTIVE & (edge1 | edge2);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            fcnt       <= 8'd0;
            coins_left <= 2'd0;
            plr        <= 1'b0;
            COIN       <= 1'b0;
            START1     <= 1'b0;
            START2     <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_n;
            fcnt       <= fcnt_n;
            coins_left <= coins_n;
            plr        <= plr_n;
            COIN       <= coin_d;
            START1     <= start1_d;
            START2     <= start2_d;
            BUSY       <= busy_d;
        end
    end

    always_comb begin
        state_n = state;
        coins_n = coins_left;
        plr_n   = plr;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = COIN_ON;
                    coins_n = edge2 ? 2'd2 : 2'd1;
                    plr_n   = edge2;
                end
            end
            COIN_ON: begin
                if (tick && (fcnt == COIN_LAST)) begin
                    state_n = COIN_GAP;
                    coins_n = coins_left - 2'd1;
                end
            end
            COIN_GAP: begin
                if (tick && (fcnt == GAP_LAST)) begin
                    state_n = (coins_left != 2'd0) ? COIN_ON : START_ON;
                end
            end
            START_ON: begin
                if (tick && (fcnt == START_LAST)) begin
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!req1 && !req2) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (DN_ACTIVE) begin
            state_n = IDLE;
            coins_n = 2'd0;
        end

        // Only the timed states count; a fresh state always starts from zero.
        counting = (state == COIN_ON) || (state == COIN_GAP) || (state == START_ON);
        if (DN_ACTIVE || (state_n != state) || !counting) begin
            fcnt_n = 8'd0;
        end else if (tick) begin
            fcnt_n = fcnt + 8'd1;
        end else begin
            fcnt_n = fcnt;
        end
    end

    always_comb begin
        coin_d   = (state_n == COIN_ON);
        start1_d = (state_n == START_ON) && !plr_n;
        start2_d = (state_n == START_ON) && plr_n;
        busy_d   = (state_n != IDLE);
    end

endmodule
